// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch unit: fetch FSM state
// encoding, instruction field positions and the default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH_REQ,
        FETCH_WAIT,
        HOLD
    } fetchState_t;

    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;
    localparam int unsigned FUNCT_MSB   = 5;
    localparam int unsigned FUNCT_LSB   = 0;
    localparam int unsigned IMM16_MSB   = 15;
    localparam int unsigned IMM16_LSB   = 0;
    localparam int unsigned JADDR26_MSB = 25;
    localparam int unsigned JADDR26_LSB = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel
// Purely combinational next-PC selection for the fetch unit.
// Ports:
//   pcPlus4       in  32  PC of the retiring instruction + 4
//   instr         in  32  retiring instruction word (IR)
//   controlJump   in  1   decoder jump flag
//   controlBranch in  1   decoder branch flag
//   aluZero       in  1   ALU zero flag
//   nextPc        out 32  selected next PC (jump > taken branch > pcPlus4)
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pcPlus4,
    input  logic [31:0] instr,
    input  logic        controlJump,
    input  logic        controlBranch,
    input  logic        aluZero,
    output logic [31:0] nextPc
);

    logic [31:0] branchOffset;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;

    always_comb begin
        // Sign-extended word offset, already scaled to bytes.
        branchOffset = {{14{instr[IMM16_MSB]}}, instr[IMM16_MSB:IMM16_LSB], 2'b00};
        branchTarget = pcPlus4 + branchOffset;
        // Jump stays within the 256 MB region of the delay-slot address.
        jumpTarget   = {pcPlus4[31:28], instr[JADDR26_MSB:JADDR26_LSB], 2'b00};

        nextPc = pcPlus4;
        if (controlJump) begin
            nextPc = jumpTarget;
        end else if (controlBranch && aluZero) begin
            nextPc = branchTarget;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Holds the PC, fetches one instruction at a time over a valid/ready
// memory interface, latches it into the IR and presents it to the decoder.
// The decoder's branch/jump decision selects the next PC on retirement.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   imemReqValid/imemReqReady/imemAddr  fetch request (imemAddr = PC)
//   imemRespValid/imemRespData        fetch response
//   instrValid/instrAccept            IR hand-off to the decoder
//   instruction, instructionOpcode, instructionFunct  IR and its fields
//   pcOut, pcPlus4                    PC of the IR instruction and PC+4
//   controlBranch, controlJump, aluZero  next-PC decision, sampled on accept
// Optional (macro FETCH_PERF_CNT_EN):
//   retiredCount   out 32  accepted instructions
//   memStallCount  out 32  cycles waiting on memory ready/response
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        instrValid,
    input  logic        instrAccept,
    output logic [31:0] instruction,
    output logic [5:0]  instructionOpcode,
    output logic [5:0]  instructionFunct,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    input  logic        controlBranch,
    input  logic        controlJump,
    input  logic        aluZero
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retiredCount,
    output logic [31:0] memStallCount
`endif
);

    fetchState_t state;
    fetchState_t nextState;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] nextPc;
    logic        retire;

    next_pc_sel uNextPcSel (
        .pcPlus4       (pcPlus4),
        .instr         (ir),
        .controlJump   (controlJump),
        .controlBranch (controlBranch),
        .aluZero       (aluZero),
        .nextPc        (nextPc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        imemReqValid = 1'b0;
        instrValid   = 1'b0;
        retire       = 1'b0;
        case (state)
            BOOT: begin
                nextState = FETCH_REQ;
            end
            FETCH_REQ: begin
                imemReqValid = 1'b1;
                if (imemReqReady) begin
                    nextState = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imemRespValid) begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                instrValid = 1'b1;
                if (instrAccept) begin
                    retire    = 1'b1;
                    nextState = FETCH_REQ;
                end
            end
            default: begin
                nextState = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            if (state == FETCH_WAIT && imemRespValid) begin
                ir <= imemRespData;
            end
            if (retire) begin
                pc <= nextPc;
            end
        end
    end

    always_comb begin
        imemAddr          = pc;
        pcOut             = pc;
        pcPlus4           = pc + 32'd4;
        instruction       = ir;
        instructionOpcode = ir[OPCODE_MSB:OPCODE_LSB];
        instructionFunct  = ir[FUNCT_MSB:FUNCT_LSB];
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retiredCount  <= '0;
            memStallCount <= '0;
        end else begin
            if (retire) begin
                retiredCount <= retiredCount + 32'd1;
            end
            if ((state == FETCH_REQ && !imemReqReady) ||
                (state == FETCH_WAIT && !imemRespValid)) begin
                memStallCount <= memStallCount + 32'd1;
            end
        end
    end
`endif

endmodule
